alu_operand_sequencer: RTL

- Byte-serial front end that sits directly upstream of the 8-bit ALU (alu_8bits).
- The top-level has a single 8-bit input bus, so operands and opcode cannot be presented in parallel. This block collects an opcode byte, operand A and operand B over successive handshakes, then drives them as registered, stable signals into the ALU's a/b/S inputs.
- It waits a fixed settling time, captures the ALU Result and presents it on a valid/ready output.

---
 rtl/alu_operand_sequencer.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: byte-serial front end for the 8-bit ALU.
// Collects opcode, operand A and operand B over in_valid/in_ready handshakes.
// Drives them as held registers into the ALU, waits ALU_LAT cycles, then
// presents the captured result on out_valid/out_ready.
// Optional feature macro: ALU_SEQ_CHAIN_EN. When defined, opcode bit 7 chains
// the previous result into operand A and skips loading A.
module alu_operand_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SEL_W   = 2,
    parameter int unsigned ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_s,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       op_count
);

    localparam int unsigned CntW = 4;

    typedef enum logic [2:0] {
        StLdOp,
        StLdA,
        StLdB,
        StExec,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0] alu_s_q, alu_s_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       op_count_q, op_count_d;
    logic             load_state;

    // Next-state and datapath updates; registers hold unless their own accept occurs.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_s_d     = alu_s_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        op_count_d  = op_count_q;
        load_state  = 1'b0;

        unique case (state_q)
            StLdOp: begin
                load_state = 1'b1;
                if (in_valid) begin
                    alu_s_d = in_data[SEL_W-1:0];
                    state_d = StLdA;
`ifdef ALU_SEQ_CHAIN_EN
                    // Chain: previous result becomes operand A, skip loading A.
                    if (in_data[7]) begin
                        alu_a_d = out_data_q;
                        state_d = StLdB;
                    end
`endif
                end
            end
            StLdA: begin
                load_state = 1'b1;
                if (in_valid) begin
                    alu_a_d = in_data;
                    state_d = StLdB;
                end
            end
            StLdB: begin
                load_state = 1'b1;
                if (in_valid) begin
                    alu_b_d = in_data;
                    cnt_d   = CntW'(ALU_LAT - 1);
                    state_d = StExec;
                end
            end
            StExec: begin
                if (cnt_q == '0) begin
                    out_data_d  = alu_result;
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    op_count_d  = op_count_q + 8'd1;
                    state_d     = StLdOp;
                end
            end
            default: state_d = StLdOp;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StLdOp;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_s_q     <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_s_q     <= alu_s_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            op_count_q  <= op_count_d;
        end
    end

    // Outputs; in_ready is forced low while reset is held so every output reads 0.
    always_comb begin
        in_ready  = load_state & ~rst;
        alu_a     = alu_a_q;
        alu_b     = alu_b_q;
        alu_s     = alu_s_q;
        out_data  = out_data_q;
        out_valid = out_valid_q;
        op_count  = op_count_q;
    end

endmodule
